lisa_autobaud: RTL and testbench

Autobaud detector for the LISA debug UART path. It sits directly upstream of `debug_brg`. It watches the serial receive line for a host-sent 0x55 sync character, measures the bit period in system clocks, and drives `baud_div`/`baud_set` into the baud-rate generator so that `lisa_rx8n`/`lisa_tx8n` lock to the host rate without firmware involvement.

---
 rtl/lisa_autobaud_pkg.sv | 29 ++
 rtl/lisa_autobaud_sync.sv | 34 +++
 rtl/lisa_autobaud.sv | 180 ++++++++++++++++++
 tb/tb_lisa_autobaud.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/lisa_autobaud_pkg.sv
// Shared types and constants for the LISA autobaud detector.
//   state_e      - measurement FSM states
//   TolShift     - interval tolerance is I0 >> TolShift
//   round_add()  - rounding term added to the 8-bit-period count T
//   round_shift()- shift that turns the rounded T into clocks per oversample tick
package lisa_autobaud_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StMeasure,
    StCheck,
    StLocked,
    StErr
  } state_e;

  localparam int unsigned TolShift = 2;

  // T spans 8 bits of OSR ticks each, so a shift of OSR_LOG2+3 gives clocks per tick;
  // adding half of that divisor rounds to nearest.
  function automatic int unsigned round_add(input int unsigned osr_log2);
    return 1 << (osr_log2 + 2);
  endfunction

  function automatic int unsigned round_shift(input int unsigned osr_log2);
    return osr_log2 + 3;
  endfunction

endpackage

// File: rtl/lisa_autobaud_sync.sv
// Two-flop synchronizer with a registered falling-edge detector for an async line.
//   i_clk, i_rst_n - clock, synchronous active-low reset
//   i_async        - asynchronous input, idle high
//   o_level        - synchronized level
//   o_fall         - one-cycle pulse, three clocks after a falling pin edge
module lisa_autobaud_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_fall
);

  logic r_s1, r_s2, r_s3, r_fall;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      // Reset to the idle-high level so reset release does not look like an edge.
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_s3   <= 1'b1;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_fall <= r_s3 & ~r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_fall  = r_fall;

endmodule

// File: rtl/lisa_autobaud.sv
// Autobaud detector: measures a 0x55 sync character on i_rxd and drives the divider
// for the debug baud-rate generator.
//   i_clk, i_rst_n - clock, synchronous active-low reset
//   i_rxd          - async serial line, idle high
//   i_restart      - one-cycle request to drop the lock and re-measure
//   o_baud_div     - divider value (DEFAULT_DIV until first lock)
//   o_baud_set     - high while o_baud_div holds a measured value
//   o_locked       - high in the locked state
//   o_err          - sticky measurement failure flag
module lisa_autobaud
  import lisa_autobaud_pkg::*;
#(
  parameter int unsigned OSR_LOG2    = 3,
  parameter int unsigned DIV_W       = 7,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned IDLE_CLKS   = 64,
  parameter int unsigned DEFAULT_DIV = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rxd,
  input  logic             i_restart,
  output logic [DIV_W-1:0] o_baud_div,
  output logic             o_baud_set,
  output logic             o_locked,
  output logic             o_err
);

  localparam int unsigned IdleW    = $clog2(IDLE_CLKS + 1);
  localparam int unsigned RndAdd   = round_add(OSR_LOG2);
  localparam int unsigned RndShift = round_shift(OSR_LOG2);
  localparam logic [CNT_W:0] QMax  = (CNT_W+1)'(2 ** DIV_W);

  logic w_level, w_fall;

  lisa_autobaud_sync u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_rxd),
    .o_level (w_level),
    .o_fall  (w_fall)
  );

  state_e             r_state, w_state_nxt;
  logic [IdleW-1:0]   r_idle, w_idle_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, r_ivl, w_ivl_nxt;
  logic [CNT_W-1:0]   r_i0, w_i0_nxt, r_t, w_t_nxt;
  logic [2:0]         r_edge, w_edge_nxt;
  logic [DIV_W-1:0]   r_div, w_div_nxt;
  logic               r_set, w_set_nxt, r_locked, w_locked_nxt, r_err, w_err_nxt;

  // Counts include the current cycle, so T comes out as exactly 8 bit periods.
  logic [CNT_W-1:0] w_cnt_inc, w_ivl_inc, w_diff;
  logic             w_ivl_ok;
  logic [CNT_W:0]   w_sum, w_q;
  logic             w_q_ok;

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_ivl_inc = r_ivl + CNT_W'(1);
  assign w_diff    = (w_ivl_inc >= r_i0) ? (w_ivl_inc - r_i0) : (r_i0 - w_ivl_inc);
  assign w_ivl_ok  = (w_diff <= (r_i0 >> TolShift));
  assign w_sum     = {1'b0, r_t} + (CNT_W+1)'(RndAdd);
  assign w_q       = w_sum >> RndShift;
  assign w_q_ok    = (w_q != '0) && (w_q <= QMax);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_idle  <= '0;
      r_cnt   <= '0;
      r_ivl   <= '0;
      r_i0    <= '0;
      r_t     <= '0;
      r_edge  <= '0;
      r_div   <= DIV_W'(DEFAULT_DIV);
      r_set   <= 1'b0;
      r_locked <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idle  <= w_idle_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ivl   <= w_ivl_nxt;
      r_i0    <= w_i0_nxt;
      r_t     <= w_t_nxt;
      r_edge  <= w_edge_nxt;
      r_div   <= w_div_nxt;
      r_set   <= w_set_nxt;
      r_locked <= w_locked_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idle_nxt   = r_idle;
    w_cnt_nxt    = r_cnt;
    w_ivl_nxt    = r_ivl;
    w_i0_nxt     = r_i0;
    w_t_nxt      = r_t;
    w_edge_nxt   = r_edge;
    w_div_nxt    = r_div;
    w_set_nxt    = r_set;
    w_locked_nxt = r_locked;
    w_err_nxt    = r_err;

    if (i_restart) begin
      w_state_nxt  = StIdle;
      w_idle_nxt   = '0;
      w_set_nxt    = 1'b0;
      w_locked_nxt = 1'b0;
      w_err_nxt    = 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (!w_level) begin
            w_idle_nxt = '0;
          end else if (r_idle == IdleW'(IDLE_CLKS - 1)) begin
            w_idle_nxt  = '0;
            w_state_nxt = StArmed;
          end else begin
            w_idle_nxt = r_idle + IdleW'(1);
          end
        end
        StArmed: begin
          if (w_fall) begin
            w_cnt_nxt   = '0;
            w_ivl_nxt   = '0;
            w_edge_nxt  = 3'd1;
            w_state_nxt = StMeasure;
          end
        end
        StMeasure: begin
          w_cnt_nxt = w_cnt_inc;
          w_ivl_nxt = w_ivl_inc;
          if (r_cnt == '1) begin
            w_state_nxt = StErr;
          end else if (w_fall) begin
            w_ivl_nxt  = '0;
            w_edge_nxt = r_edge + 3'd1;
            if (r_edge == 3'd1) begin
              w_i0_nxt = w_ivl_inc;
            end else if (!w_ivl_ok) begin
              w_state_nxt = StErr;
            end else if (r_edge == 3'd4) begin
              w_t_nxt     = w_cnt_inc;
              w_state_nxt = StCheck;
            end
          end
        end
        StCheck: begin
          if (w_q_ok) begin
            w_div_nxt    = DIV_W'(w_q - (CNT_W+1)'(1));
            w_set_nxt    = 1'b1;
            w_locked_nxt = 1'b1;
            w_state_nxt  = StLocked;
          end else begin
            w_state_nxt = StErr;
          end
        end
        StLocked: ;
        StErr:    w_state_nxt = StIdle;
        default:  w_state_nxt = StIdle;
      endcase

      // Raise the flag in the same edge that enters ERR so outputs stay registered.
      if (w_state_nxt == StErr) begin
        w_err_nxt    = 1'b1;
        w_set_nxt    = 1'b0;
        w_locked_nxt = 1'b0;
      end
    end
  end

  assign o_baud_div = r_div;
  assign o_baud_set = r_set;
  assign o_locked   = r_locked;
  assign o_err      = r_err;

endmodule

// File: tb/tb_lisa_autobaud.sv
module tb_lisa_autobaud;

  // Narrower period counter keeps the timeout case short; all other cases fit in it.
  localparam int unsigned CntW = 14;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       restart = 1'b0;
  logic [6:0] baud_div;
  logic       baud_set, locked, err;

  int n_cmp = 0;
  int n_fail = 0;

  lisa_autobaud #(
    .OSR_LOG2    (3),
    .DIV_W       (7),
    .CNT_W       (CntW),
    .IDLE_CLKS   (64),
    .DEFAULT_DIV (3)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rxd      (rxd),
    .i_restart  (restart),
    .o_baud_div (baud_div),
    .o_baud_set (baud_set),
    .o_locked   (locked),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int div, input int set, input int lck,
                           input int er);
    check({tag, ".baud_div"}, 32'(baud_div), 32'(div));
    check({tag, ".baud_set"}, 32'(baud_set), 32'(set));
    check({tag, ".locked"}, 32'(locked), 32'(lck));
    check({tag, ".err"}, 32'(err), 32'(er));
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    tick(n);
  endtask

  // Start bit plus data bits 0..6, LSB first.
  task automatic frame_head(input logic [7:0] b, input int bclk);
    rxd = 1'b0;
    tick(bclk);
    for (int i = 0; i < 7; i++) begin
      rxd = b[i];
      tick(bclk);
    end
  endtask

  task automatic frame_tail(input logic [7:0] b, input int bclk);
    rxd = b[7];
    tick(bclk);
    rxd = 1'b1;
    tick(bclk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int bclk);
    frame_head(b, bclk);
    frame_tail(b, bclk);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
  endtask

  initial begin
    // Reset values
    tick(3);
    check_out("reset", 3, 0, 0, 0);
    rst_n = 1'b1;

    // 0x55 at 32 clk/bit: T=256, q=4, div=3; lock lands 5 clocks after the last pin fall
    idle(100);
    frame_head(8'h55, 32);
    rxd = 1'b0;
    tick(4);
    check("lock32.early", 32'(locked), 32'd0);
    tick(1);
    check_out("lock32", 3, 1, 1, 0);
    tick(27);
    rxd = 1'b1;
    tick(32);

    // restart clears lock on the next edge, divider kept
    pulse_restart();
    check_out("restart1", 3, 0, 0, 0);

    // 0x0F then 0x55: intervals 160,160,64 -> mismatch at edge 4
    idle(100);
    send_byte(8'h0F, 32);
    send_byte(8'h55, 32);
    idle(10);
    check_out("mismatch", 3, 0, 0, 1);
    pulse_restart();
    check("mismatch.clr", 32'(err), 32'd0);

    // 0x55 at 100 clk/bit: T=800, q=13, div=12; later frame at 40 clk/bit ignored
    idle(100);
    send_byte(8'h55, 100);
    idle(10);
    check_out("lock100", 12, 1, 1, 0);
    idle(100);
    send_byte(8'h55, 40);
    idle(10);
    check_out("lock100.hold", 12, 1, 1, 0);

    // Only 40 idle clocks: never arms
    pulse_restart();
    rxd = 1'b0;
    tick(10);
    idle(40);
    send_byte(8'h55, 32);
    idle(5);
    check_out("short_idle", 12, 0, 0, 0);

    // 2 clk/bit: T=16, q=0 -> err
    pulse_restart();
    idle(100);
    send_byte(8'h55, 2);
    idle(10);
    check_out("q_zero", 12, 0, 0, 1);

    // 1100 clk/bit: T=8800, q=138 > 128 -> err
    pulse_restart();
    check("q_zero.clr", 32'(err), 32'd0);
    idle(100);
    send_byte(8'h55, 1100);
    idle(10);
    check_out("q_big", 12, 0, 0, 1);

    // Line stuck low after start: counter saturates -> timeout err
    pulse_restart();
    idle(100);
    rxd = 1'b0;
    tick(16370);
    check("timeout.before", 32'(err), 32'd0);
    tick(30);
    check_out("timeout", 12, 0, 0, 1);

    // restart mid-measure, then a clean 0x55 at 32 clk/bit
    idle(100);
    frame_head(8'h55, 32);
    pulse_restart();
    check_out("restart_meas", 12, 0, 0, 0);
    frame_tail(8'h55, 32);
    idle(100);
    send_byte(8'h55, 32);
    idle(10);
    check_out("relock32", 3, 1, 1, 0);

    // Relock at 100 clk/bit, then reset mid-measure returns everything to reset values
    pulse_restart();
    idle(100);
    send_byte(8'h55, 100);
    idle(10);
    check("relock100.div", 32'(baud_div), 32'd12);
    pulse_restart();
    idle(100);
    frame_head(8'h55, 32);
    rst_n = 1'b0;
    tick(1);
    check_out("reset_meas", 3, 0, 0, 0);
    rst_n = 1'b1;
    frame_tail(8'h55, 32);
    idle(10);
    check_out("reset_meas.after", 3, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
